// File: rtl/serial_adder_pkg.sv
// Shared constants for the serial pair adder.
// State encoding, FSM state type and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_pair_adder_ctrl_add2.sv
// add2_slice: combinational 2-bit adder with carry-in.
// Ports: a, b (2b operands), ci (carry in), s (2b sum), co (carry out).
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic [2:0] t;

  assign t  = {1'b0, a} + {1'b0, b} + {2'b00, ci};
  assign s  = t[1:0];
  assign co = t[2];

endmodule

// File: rtl/serial_pair_adder_ctrl.sv
// Serial adder: one 2-bit slice reused WIDTH/2 cycles, LSB pair first.
// Ports: clk, rst (async high), in_valid/in_ready/op_a/op_b (operand side),
// out_valid/out_ready/sum/cout (result side), busy (RUN or DONE).
// Optional SERIAL_ADDER_SUB_EN adds input sub selecting op_a - op_b.
module serial_pair_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH / 2) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("serial_pair_adder_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             sub_mode;
  logic [1:0]       s_res;
  logic             s_co;
  logic [WIDTH-1:0] sum_nxt;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_mode = sub;
`else
  assign sub_mode = 1'b0;
`endif

  add2_slice u_slice (
    .a  (a_sh[1:0]),
    .b  (b_sh[1:0]),
    .ci (carry),
    .s  (s_res),
    .co (s_co)
  );

  // New pair enters at the MSB end; after WIDTH/2 shifts
  // the first pair has reached bits [1:0].
  assign sum_nxt = WIDTH'({s_res, sum} >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (in_valid) begin
            a_sh     <= op_a;
            // subtract = add inverted b with carry-in 1
            b_sh     <= op_b ^ {WIDTH{sub_mode}};
            carry    <= sub_mode;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        (state == RUN): begin
          sum   <= sum_nxt;
          carry <= s_co;
          a_sh  <= a_sh >> 2;
          b_sh  <= b_sh >> 2;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            cout      <= s_co;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        (state == DONE): begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_pair_adder_ctrl.sv
// Bench for serial_pair_adder_ctrl: WIDTH=8 and WIDTH=2 instances,
// directed plan cases plus random ops against an arithmetic model.
module tb_serial_pair_adder_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic       iv8, ir8, ov8, ordy8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       iv2, ir2, ov2, ordy2, cout2, busy2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8, sub2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  serial_pair_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .op_a      (a8),
    .op_b      (b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub8),
`endif
    .out_valid (ov8),
    .out_ready (ordy8),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  serial_pair_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv2),
    .in_ready  (ir2),
    .op_a      (a2),
    .op_b      (b2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub2),
`endif
    .out_valid (ov2),
    .out_ready (ordy2),
    .sum       (sum2),
    .cout      (cout2),
    .busy      (busy2)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // {cout, sum}: add is plain a+b; subtract gives (a-b) mod 256
  // with cout meaning "no borrow", i.e. a >= b.
  function automatic logic [8:0] model8(int a, int b, bit sb);
    int d;
    if (!sb) return 9'(a + b);
    d = (a - b) & 32'hFF;
    return {(a >= b) ? 1'b1 : 1'b0, d[7:0]};
  endfunction

  // Called at a negedge with the DUT idle. hold = cycles of
  // backpressure in DONE; bp_iv drives a competing op 1+1 meanwhile.
  task automatic op8(logic [7:0] a, logic [7:0] b, bit sb, int hold,
                     bit bp_iv);
    logic [8:0] exp;
    int lat;
    exp = model8(int'(a), int'(b), sb);
    a8 = a; b8 = b; iv8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = sb;
`endif
    ordy8 = (hold == 0);
    check("in_ready_idle", ir8, 1);
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    check("in_ready_run", ir8, 0);
    check("busy_run", busy8, 1);
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      lat++;
    end
    check("latency", lat, 4);
    if (lat >= 20) return;
    check("sum", sum8, exp[7:0]);
    check("cout", cout8, exp[8]);
    if (bp_iv) begin
      iv8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", ov8, 1);
      check("bp_sum", sum8, exp[7:0]);
      check("bp_in_ready", ir8, 0);
    end
    ordy8 = 1'b1;
    @(negedge clk);
    check("ov_drop", ov8, 0);
    check("in_ready_back", ir8, 1);
    check("busy_idle", busy8, 0);
    check("sum_kept", sum8, exp[7:0]);
    ordy8 = 1'b0;
  endtask

  task automatic op2(logic [1:0] a, logic [1:0] b);
    int s;
    int lat;
    s = int'(a) + int'(b);
    a2 = a; b2 = b; iv2 = 1'b1; ordy2 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub2 = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    lat = 0;
    while (!ov2 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w2_latency", lat, 1);
    check("w2_sum", sum2, s & 3);
    check("w2_cout", cout2, s >> 2);
    @(negedge clk);
    check("w2_ov_drop", ov2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0;
    iv2 = 1'b0; ordy2 = 1'b0; a2 = '0; b2 = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'b0; sub2 = 1'b0;
`endif
    #12;
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_busy", busy8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op8(8'h00, 8'h00, 1'b0, 0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1, 1'b0);
    op8(8'hA5, 8'h5A, 1'b0, 0, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 2, 1'b0);

    // backpressure with a competing op held valid throughout;
    // it may only be taken on the edge after DONE is left
    op8(8'h3C, 8'h11, 1'b0, 3, 1'b1);
    op8(8'h01, 8'h01, 1'b0, 0, 1'b0);

    // abort mid-RUN: partial sum of 0x33+0x11 is nonzero here
    a8 = 8'h33; b8 = 8'h11; iv8 = 1'b1; ordy8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_busy", busy8, 1);
    check("pre_rst_sum", sum8, 8'h40);
    rst = 1'b1;
    #1;
    check("arst_out_valid", ov8, 0);
    check("arst_sum", sum8, 0);
    check("arst_cout", cout8, 0);
    check("arst_busy", busy8, 0);
    check("arst_in_ready", ir8, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_aborted_result", ov8, 0);
    end
    ordy8 = 1'b0;
    op8(8'h12, 8'h34, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op8(8'h10, 8'h01, 1'b1, 0, 1'b0);
    op8(8'h00, 8'h01, 1'b1, 1, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      bit sb;
      sb = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sb = 1'($urandom);
`endif
      op8(8'($urandom), 8'($urandom), sb, int'($urandom_range(0, 3)),
          1'b0);
    end

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        op2(2'(a), 2'(b));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
